// File: rtl/win_strike_drawer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// win_strike_drawer : selects the winning line and streams its strike pixels.
// Rev 1.0
// ----------------------------------------------------------------------------
module win_strike_drawer #(
  parameter int ORIGIN = 5,
  parameter int LEN    = 110,
  parameter int THICK  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] win_code,
  input  logic [8:0] rec1,
  input  logic [8:0] rec2,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [2:0] line_id,
  output logic       line_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] c_k_first = 8'(ORIGIN);
  localparam logic [7:0] c_k_last  = 8'(ORIGIN + LEN - 1);
  localparam logic [7:0] c_anti    = 8'(2 * ORIGIN + LEN - 1);
  localparam logic [1:0] c_t_last  = 2'(THICK - 1);
  localparam logic [7:0] c_t_bias  = 8'((THICK - 1) / 2);

  state_t     state_q;
  logic [3:0] code_q;
  logic [8:0] rec1_q;
  logic [8:0] rec2_q;
  logic [7:0] k_q;
  logic [1:0] t_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;
  logic       busy_q;
  logic       done_q;
  logic [2:0] line_id_q;
  logic       line_valid_q;

  logic [7:0] k_d;
  logic [1:0] t_d;
  logic [2:0] id_d;
  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [7:0] w_off;
  logic       w_p1_win;
  logic       w_p2_win;
  logic [8:0] w_rec_sel;
  logic       w_found;
  logic [2:0] w_found_id;
  logic       w_last_px;

  function automatic logic [8:0] line_mask(input logic [2:0] id);
    case (id)
      3'd0:    line_mask = 9'b111000000;
      3'd1:    line_mask = 9'b000111000;
      3'd2:    line_mask = 9'b000000111;
      3'd3:    line_mask = 9'b100100100;
      3'd4:    line_mask = 9'b010010010;
      3'd5:    line_mask = 9'b001001001;
      3'd6:    line_mask = 9'b100010001;
      default: line_mask = 9'b001010100;
    endcase
  endfunction

  // Centre coordinate of the cell column/row a straight line passes through.
  function automatic logic [7:0] lane_pos(input logic [2:0] id);
    case (id)
      3'd0, 3'd3: lane_pos = 8'd20;
      3'd1, 3'd4: lane_pos = 8'd60;
      default:    lane_pos = 8'd100;
    endcase
  endfunction

  always_comb begin
    w_p1_win   = (code_q == 4'b1011);
    w_p2_win   = (code_q == 4'b1010);
    w_rec_sel  = w_p1_win ? rec1_q : rec2_q;
    w_found    = 1'b0;
    w_found_id = 3'd0;
    // Walk downwards so the lowest-numbered complete line wins.
    for (int i = 7; i >= 0; i--) begin
      if ((w_rec_sel & line_mask(3'(i))) == line_mask(3'(i))) begin
        w_found    = 1'b1;
        w_found_id = 3'(i);
      end
    end

    w_last_px = (k_q == c_k_last) && (t_q == c_t_last);

    if (state_q == S_SCAN) begin
      k_d  = c_k_first;
      t_d  = 2'd0;
      id_d = w_found_id;
    end else if (t_q == c_t_last) begin
      k_d  = k_q + 8'd1;
      t_d  = 2'd0;
      id_d = line_id_q;
    end else begin
      k_d  = k_q;
      t_d  = t_q + 2'd1;
      id_d = line_id_q;
    end

    w_off = 8'(t_d) - c_t_bias;
    case (id_d)
      3'd0, 3'd1, 3'd2: begin
        x_d = lane_pos(id_d) + w_off;
        y_d = 7'(k_d);
      end
      3'd3, 3'd4, 3'd5: begin
        x_d = k_d;
        y_d = 7'(lane_pos(id_d) + w_off);
      end
      3'd6: begin
        x_d = k_d;
        y_d = 7'(k_d + w_off);
      end
      default: begin
        x_d = k_d;
        y_d = 7'(c_anti - k_d + w_off);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      code_q       <= 4'd0;
      rec1_q       <= 9'd0;
      rec2_q       <= 9'd0;
      k_q          <= 8'd0;
      t_q          <= 2'd0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= 3'd0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      line_id_q    <= 3'd0;
      line_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            code_q  <= win_code;
            rec1_q  <= rec1;
            rec2_q  <= rec2;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if ((w_p1_win || w_p2_win) && w_found) begin
            line_valid_q <= 1'b1;
            line_id_q    <= w_found_id;
            colour_q     <= w_p1_win ? 3'b100 : 3'b010;
            plot_q       <= 1'b1;
            x_q          <= x_d;
            y_q          <= y_d;
            k_q          <= k_d;
            t_q          <= t_d;
            state_q      <= S_DRAW;
          end else begin
            line_valid_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DRAW: begin
          if (w_last_px) begin
            plot_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            x_q <= x_d;
            y_q <= y_d;
            k_q <= k_d;
            t_q <= t_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign line_id    = line_id_q;
  assign line_valid = line_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_win_strike_drawer.sv
`default_nettype none
// tb_win_strike_drawer : scoreboard bench with a THICK=1 (u0) and a THICK=3 (u1) instance.
module tb_win_strike_drawer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] start = 2'b00;
  logic [3:0] win_code = 4'd0;
  logic [8:0] rec1 = 9'd0;
  logic [8:0] rec2 = 9'd0;

  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] c0, c1, id0, id1;
  logic       p0, p1, b0, b1, d0, d1, v0, v1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_s = 0;

  typedef struct packed {
    int         d;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } px_t;

  typedef struct packed {
    int         d;
    int         cyc;
    logic [2:0] id;
    logic       v;
  } dn_t;

  px_t exp_px[$];
  dn_t exp_dn[$];

  win_strike_drawer #(.ORIGIN(5), .LEN(110), .THICK(1)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .win_code(win_code),
    .rec1(rec1), .rec2(rec2), .x(x0), .y(y0), .colour(c0), .plot(p0),
    .busy(b0), .done(d0), .line_id(id0), .line_valid(v0)
  );

  win_strike_drawer #(.ORIGIN(5), .LEN(110), .THICK(3)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .win_code(win_code),
    .rec1(rec1), .rec2(rec2), .x(x1), .y(y1), .colour(c1), .plot(p1),
    .busy(b1), .done(d1), .line_id(id1), .line_valid(v1)
  );

  task automatic mon(input int d, input logic p, input logic [7:0] xx, input logic [6:0] yy,
                     input logic [2:0] cc, input logic dn, input logic bz,
                     input logic [2:0] lid, input logic lv);
    px_t e;
    dn_t f;
    if (p) begin
      checks++;
      if (exp_px.size() == 0 || exp_px[0].d != d) begin
        errors++;
        $display("FAIL plot_unexpected dut%0d cyc %0d: got x=%0d y=%0d, expected no plot", d, cyc, xx, yy);
      end else begin
        e = exp_px.pop_front();
        if (xx !== e.x || yy !== e.y || cc !== e.c) begin
          errors++;
          $display("FAIL pixel dut%0d cyc %0d: got x=%0d y=%0d c=%b, expected x=%0d y=%0d c=%b",
                   d, cyc, xx, yy, cc, e.x, e.y, e.c);
        end
      end
    end
    if (dn) begin
      checks++;
      if (exp_dn.size() == 0 || exp_dn[0].d != d) begin
        errors++;
        $display("FAIL done_unexpected dut%0d cyc %0d: got done=1, expected none", d, cyc);
      end else begin
        f = exp_dn.pop_front();
        if (cyc != f.cyc || lv !== f.v || (f.v && lid !== f.id) || bz !== 1'b1 || exp_px.size() != 0) begin
          errors++;
          $display("FAIL done dut%0d: got cyc=%0d valid=%b id=%0d busy=%b left=%0d, expected cyc=%0d valid=%b id=%0d busy=1 left=0",
                   d, cyc, lv, lid, bz, exp_px.size(), f.cyc, f.v, f.id);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, p0, x0, y0, c0, d0, b0, id0, v0);
    mon(1, p1, x1, y1, c1, d1, b1, id1, v1);
  end

  // kind: 0 vertical at x=fix, 1 horizontal at y=fix, 2 main diagonal, 3 anti-diagonal
  task automatic issue(input int d, input logic [3:0] code, input logic [8:0] r1,
                       input logic [8:0] r2, input int kind, input int fix,
                       input logic [2:0] col, input logic [2:0] id, input logic v);
    int  th;
    int  n;
    int  off;
    px_t e;
    dn_t f;
    th = (d == 0) ? 1 : 3;
    n  = 0;
    if (v) begin
      for (int k = 5; k <= 114; k++) begin
        for (int t = 0; t < th; t++) begin
          off = t - (th - 1) / 2;
          e.d = d;
          e.c = col;
          case (kind)
            0:       begin e.x = 8'(fix + off); e.y = 7'(k);             end
            1:       begin e.x = 8'(k);         e.y = 7'(fix + off);     end
            2:       begin e.x = 8'(k);         e.y = 7'(k + off);       end
            default: begin e.x = 8'(k);         e.y = 7'(119 - k + off); end
          endcase
          exp_px.push_back(e);
          n++;
        end
      end
    end
    @(negedge clk);
    win_code = code;
    rec1     = r1;
    rec2     = r2;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    last_s   = cyc;
    f.d   = d;
    f.cyc = cyc + 1 + n;
    f.id  = id;
    f.v   = v;
    exp_dn.push_back(f);
    win_code = ~code;
    rec1     = ~r1;
    rec2     = ~r2;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_dn.size() != 0 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (exp_dn.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: done not seen, got %0d pending, expected 0", exp_dn.size());
      exp_dn.delete();
      exp_px.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if ({x0, y0, c0, p0, b0, d0, id0, v0, x1, y1, c1, p1, b1, d1, id1, v1} !== '0) begin
      errors++;
      $display("FAIL reset_state: got u0 x=%0d y=%0d p=%b b=%b v=%b u1 x=%0d y=%0d p=%b, expected all zero",
               x0, y0, p0, b0, v0, x1, y1, p1);
    end
    reset = 1'b0;

    issue(0, 4'b1011, 9'b111000000, 9'b000000000, 0, 20, 3'b100, 3'd0, 1'b1); wait_done();
    issue(0, 4'b1010, 9'b000000000, 9'b001010100, 3, 0, 3'b010, 3'd7, 1'b1); wait_done();
    issue(0, 4'b1011, 9'b111111000, 9'b000000000, 0, 20, 3'b100, 3'd0, 1'b1); wait_done();
    issue(0, 4'b1011, 9'b100100100, 9'b000000000, 1, 20, 3'b100, 3'd3, 1'b1); wait_done();
    issue(0, 4'b1101, 9'b111000000, 9'b111000000, 0, 0, 3'b000, 3'd0, 1'b0); wait_done();
    issue(0, 4'b0000, 9'b111000000, 9'b111000000, 0, 0, 3'b000, 3'd0, 1'b0); wait_done();
    issue(0, 4'b1010, 9'b111000000, 9'b100010001, 2, 0, 3'b010, 3'd6, 1'b1); wait_done();
    issue(0, 4'b1011, 9'b000000000, 9'b111111111, 0, 0, 3'b000, 3'd0, 1'b0); wait_done();
    issue(0, 4'b1010, 9'b000000000, 9'b001001001, 1, 100, 3'b010, 3'd5, 1'b1); wait_done();

    // Reset during the 50th plot cycle must abort without a done pulse.
    issue(0, 4'b1011, 9'b000111000, 9'b000000000, 0, 60, 3'b100, 3'd1, 1'b1);
    while (cyc < last_s + 50) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (p0 !== 1'b0 || b0 !== 1'b0 || d0 !== 1'b0 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_draw: got plot=%b busy=%b done=%b valid=%b, expected 0 0 0 0", p0, b0, d0, v0);
    end
    exp_px.delete();
    exp_dn.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    issue(0, 4'b1011, 9'b000111000, 9'b000000000, 0, 60, 3'b100, 3'd1, 1'b1); wait_done();

    // A start pulse during DRAW must neither restart nor add a second done.
    issue(0, 4'b1011, 9'b000000111, 9'b000000000, 0, 100, 3'b100, 3'd2, 1'b1);
    repeat (20) @(negedge clk);
    win_code = 4'b1010;
    rec2     = 9'b111000000;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done();

    issue(1, 4'b1011, 9'b010010010, 9'b000000000, 1, 60, 3'b100, 3'd4, 1'b1); wait_done();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
